// File: rtl/lsu_dmem_if.sv
// Request/response handshake bundle between the execute stage (master) and the LSU (slave).
interface lsu_dmem_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [31:0]           req_data;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_data;
  logic [TAG_WIDTH-1:0]  resp_tag;
  logic                  resp_error;

  modport master (
    output req_valid, req_store, req_funct3, req_address, req_data, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag, resp_error
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_address, req_data, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag, resp_error
  );
endinterface

// File: rtl/lsu_dmem.sv
// Load/store unit: one request at a time, alignment/funct3 check, byte-lane memory
// port with one-cycle synchronous read, and sign/zero extension of load data.
module lsu_dmem #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  lsu_dmem_if.slave             bus,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [3:0]            mem_width,
  output logic                  mem_write,
  output logic [31:0]           mem_data_out,
  input  logic [31:0]           mem_data_in
);
  localparam int unsigned DATA_WIDTH = 32;
  localparam logic [3:0]  WIDTH_B    = 4'd1;
  localparam logic [3:0]  WIDTH_H    = 4'd2;
  localparam logic [3:0]  WIDTH_W    = 4'd4;

  typedef enum logic [1:0] {IDLE, ISSUE, LOAD_WAIT, RESP} state_t;

  state_t                 state_q, state_d;
  logic                   req_ready_q, req_ready_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]  resp_data_q, resp_data_d;
  logic [TAG_WIDTH-1:0]   resp_tag_q, resp_tag_d;
  logic                   resp_error_q, resp_error_d;
  logic                   mem_write_q, mem_write_d;
  logic [3:0]             mem_width_q, mem_width_d;
  logic [ADDR_WIDTH-1:0]  mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0]  mem_data_out_q, mem_data_out_d;
  logic [2:0]             funct3_q, funct3_d;

  logic [3:0]             width_c;
  logic                   aligned_c;
  logic                   funct3_ok_c;
  logic                   legal_c;
  logic [DATA_WIDTH-1:0]  load_data_c;

  // Request decode: access width, alignment and funct3 legality
  always_comb begin
    width_c     = WIDTH_W;
    aligned_c   = 1'b0;
    funct3_ok_c = 1'b0;
    case (bus.req_funct3[1:0])
      2'd0:    begin width_c = WIDTH_B; aligned_c = 1'b1; end
      2'd1:    begin width_c = WIDTH_H; aligned_c = ~bus.req_address[0]; end
      2'd2:    begin width_c = WIDTH_W; aligned_c = (bus.req_address[1:0] == 2'b00); end
      default: begin width_c = WIDTH_W; aligned_c = 1'b0; end
    endcase
    if (bus.req_store) funct3_ok_c = (bus.req_funct3 <= 3'd2);
    else               funct3_ok_c = (bus.req_funct3 != 3'd3) && (bus.req_funct3 <= 3'd5);
    legal_c = funct3_ok_c && aligned_c;
  end

  // Memory returns data right-justified; extend according to the captured funct3
  always_comb begin
    load_data_c = mem_data_in;
    case (funct3_q)
      3'd0:    load_data_c = {{24{mem_data_in[7]}}, mem_data_in[7:0]};
      3'd1:    load_data_c = {{16{mem_data_in[15]}}, mem_data_in[15:0]};
      3'd4:    load_data_c = {24'd0, mem_data_in[7:0]};
      3'd5:    load_data_c = {16'd0, mem_data_in[15:0]};
      default: load_data_c = mem_data_in;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    req_ready_d    = req_ready_q;
    resp_valid_d   = resp_valid_q;
    resp_data_d    = resp_data_q;
    resp_tag_d     = resp_tag_q;
    resp_error_d   = resp_error_q;
    mem_write_d    = 1'b0;
    mem_width_d    = mem_width_q;
    mem_address_d  = mem_address_q;
    mem_data_out_d = mem_data_out_q;
    funct3_d       = funct3_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_ready_q && bus.req_valid) begin
          req_ready_d = 1'b0;
          funct3_d    = bus.req_funct3;
          resp_tag_d  = bus.req_tag;
          if (legal_c) begin
            state_d        = ISSUE;
            mem_address_d  = bus.req_address;
            mem_width_d    = width_c;
            mem_data_out_d = bus.req_data;
            mem_write_d    = bus.req_store;
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_data_d  = '0;
          end
        end
      end
      ISSUE: begin
        if (mem_write_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_error_d = 1'b0;
          resp_data_d  = '0;
        end else begin
          state_d = LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_error_d = 1'b0;
        resp_data_d  = load_data_c;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      req_ready_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      resp_tag_q     <= '0;
      resp_error_q   <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_width_q    <= WIDTH_W;
      mem_address_q  <= '0;
      mem_data_out_q <= '0;
      funct3_q       <= '0;
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      resp_tag_q     <= resp_tag_d;
      resp_error_q   <= resp_error_d;
      mem_write_q    <= mem_write_d;
      mem_width_q    <= mem_width_d;
      mem_address_q  <= mem_address_d;
      mem_data_out_q <= mem_data_out_d;
      funct3_q       <= funct3_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_tag   = resp_tag_q;
  assign bus.resp_error = resp_error_q;
  assign mem_address    = mem_address_q;
  assign mem_width      = mem_width_q;
  assign mem_data_out   = mem_data_out_q;
  // A store whose ISSUE cycle coincides with reset must not reach memory
  assign mem_write      = mem_write_q & ~reset;
endmodule

// File: tb/tb_lsu_dmem.sv
// Directed bench for lsu_dmem with a byte-addressed behavioural Memory model.
module tb_lsu_dmem;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_address;
  logic [3:0]  mem_width;
  logic        mem_write;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in = '0;

  int checks = 0;
  int passed = 0;
  int wr_cycles = 0;
  logic [3:0] last_wr_width = '0;
  logic [7:0] mem [0:255];

  lsu_dmem_if #(.ADDR_WIDTH(32), .TAG_WIDTH(5)) bus ();

  lsu_dmem #(.ADDR_WIDTH(32), .TAG_WIDTH(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus.slave),
    .mem_address  (mem_address),
    .mem_width    (mem_width),
    .mem_write    (mem_write),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [3:0] w);
    logic [7:0] b;
    b = a[7:0];
    case (w)
      4'd1:    return {24'd0, mem[b]};
      4'd2:    return {16'd0, mem[8'(b + 8'd1)], mem[b]};
      default: return {mem[8'(b + 8'd3)], mem[8'(b + 8'd2)], mem[8'(b + 8'd1)], mem[b]};
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [7:0] b);
    return {mem[8'(b + 8'd3)], mem[8'(b + 8'd2)], mem[8'(b + 8'd1)], mem[b]};
  endfunction

  task automatic put_word(input logic [7:0] b, input logic [31:0] v);
    mem[b] = v[7:0]; mem[8'(b + 8'd1)] = v[15:8];
    mem[8'(b + 8'd2)] = v[23:16]; mem[8'(b + 8'd3)] = v[31:24];
  endtask

  // Memory: synchronous read of the pre-write contents, little-endian byte-lane write
  always @(posedge clock) begin
    mem_data_in <= mem_rd(mem_address, mem_width);
    if (mem_write) begin
      wr_cycles++;
      last_wr_width = mem_width;
      mem[mem_address[7:0]] = mem_data_out[7:0];
      if (mem_width >= 4'd2) mem[8'(mem_address[7:0] + 8'd1)] = mem_data_out[15:8];
      if (mem_width == 4'd4) begin
        mem[8'(mem_address[7:0] + 8'd2)] = mem_data_out[23:16];
        mem[8'(mem_address[7:0] + 8'd3)] = mem_data_out[31:24];
      end
    end
  end

  task automatic set_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] t);
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
    bus.req_address = a; bus.req_data = d; bus.req_tag = t;
  endtask

  // Returns #1 after the accepting edge with req_valid dropped
  task automatic wait_accept(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = bus.req_ready;
      @(posedge clock); #1;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] t, output int lat,
                         output logic [31:0] rdata, output logic [4:0] rtag, output logic rerr);
    logic ok;
    set_req(st, f3, a, d, t);
    wait_accept(ok);
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin @(posedge clock); #1; lat++; end
    if (!ok || !bus.resp_valid) lat = 99;
    rdata = bus.resp_data; rtag = bus.resp_tag; rerr = bus.resp_error;
    bus.resp_ready = 1'b1;
    @(posedge clock); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++; if (bus.req_ready !== 1'b0) $display("FAIL rst_req_ready got %0b want 0", bus.req_ready); else passed++;
    checks++; if (bus.resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %0b want 0", bus.resp_valid); else passed++;
    checks++; if (mem_write !== 1'b0) $display("FAIL rst_mem_write got %0b want 0", mem_write); else passed++;
    checks++; if (mem_width !== 4'd4) $display("FAIL rst_mem_width got %0d want 4", mem_width); else passed++;
    checks++; if (mem_address !== 32'd0) $display("FAIL rst_mem_address got %h want 0", mem_address); else passed++;
    checks++; if ({bus.resp_data, bus.resp_tag, bus.resp_error} !== 38'd0)
      $display("FAIL rst_resp_fields got %h/%h/%b want 0", bus.resp_data, bus.resp_tag, bus.resp_error); else passed++;
    reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (bus.req_ready !== 1'b1) $display("FAIL rst_ready_after got %0b want 1", bus.req_ready); else passed++;
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [31:0] adr [5] = '{32'h40, 32'h43, 32'h42, 32'h40, 32'h40};
    logic [31:0] exp [5] = '{32'hFFFFFF82, 32'h00000080, 32'hFFFF80F1, 32'h00007F82, 32'h80F17F82};
    int lat; logic [31:0] rd; logic [4:0] rt; logic re;
    put_word(8'h40, 32'h80F17F82);
    for (int i = 0; i < 5; i++) begin
      run_req(1'b0, f3[i], adr[i], 32'hDEAD0000, 5'(i + 10), lat, rd, rt, re);
      checks++; if (rd !== exp[i]) $display("FAIL load%0d_data got %h want %h", i, rd, exp[i]); else passed++;
      checks++; if (lat != 3) $display("FAIL load%0d_latency got %0d want 3", i, lat); else passed++;
      checks++; if (rt !== 5'(i + 10) || re !== 1'b0) $display("FAIL load%0d_tag_err got %0d/%0b want %0d/0", i, rt, re, i + 10); else passed++;
    end
  endtask

  task automatic test_store_byte();
    int lat; logic [31:0] rd; logic [4:0] rt; logic re; int w0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    w0 = wr_cycles;
    run_req(1'b1, 3'd0, 32'h45, 32'h12345678, 5'd3, lat, rd, rt, re);
    checks++; if (lat != 2) $display("FAIL sb_latency got %0d want 2", lat); else passed++;
    checks++; if (wr_cycles - w0 != 1) $display("FAIL sb_write_cycles got %0d want 1", wr_cycles - w0); else passed++;
    checks++; if (last_wr_width !== 4'd1) $display("FAIL sb_width got %0d want 1", last_wr_width); else passed++;
    checks++; if (rd !== 32'd0 || re !== 1'b0 || rt !== 5'd3) $display("FAIL sb_resp got %h/%0b/%0d want 0/0/3", rd, re, rt); else passed++;
    run_req(1'b0, 3'd2, 32'h44, 32'd0, 5'd4, lat, rd, rt, re);
    checks++; if (rd !== 32'h00007800) $display("FAIL sb_readback got %h want 00007800", rd); else passed++;
  endtask

  task automatic test_errors();
    logic        st  [3] = '{1'b0, 1'b0, 1'b1};
    logic [2:0]  f3  [3] = '{3'd1, 3'd2, 3'd4};
    logic [31:0] adr [3] = '{32'h41, 32'h42, 32'h48};
    int lat; logic [31:0] rd; logic [4:0] rt; logic re; int w0;
    w0 = wr_cycles;
    for (int i = 0; i < 3; i++) begin
      run_req(st[i], f3[i], adr[i], 32'hFFFFFFFF, 5'(20 + i), lat, rd, rt, re);
      checks++; if (re !== 1'b1 || rd !== 32'd0) $display("FAIL err%0d_resp got %0b/%h want 1/0", i, re, rd); else passed++;
      checks++; if (lat != 1 || rt !== 5'(20 + i)) $display("FAIL err%0d_lat_tag got %0d/%0d want 1/%0d", i, lat, rt, 20 + i); else passed++;
    end
    checks++; if (wr_cycles != w0) $display("FAIL err_no_write got %0d want %0d", wr_cycles, w0); else passed++;
    checks++; if (word_at(8'h48) !== 32'd0) $display("FAIL err_mem_unchanged got %h want 0", word_at(8'h48)); else passed++;
  endtask

  task automatic test_backpressure();
    logic ok; int w0; int n;
    put_word(8'h50, 32'hCAFEBABE);
    set_req(1'b0, 3'd2, 32'h50, 32'd0, 5'd7);
    wait_accept(ok);
    n = 0;
    while (!bus.resp_valid && n < 20) begin @(posedge clock); #1; n++; end
    checks++; if (!ok || bus.resp_valid !== 1'b1) $display("FAIL bp_resp_arrives got %0b want 1", bus.resp_valid); else passed++;
    w0 = wr_cycles;
    set_req(1'b1, 3'd2, 32'h54, 32'h1, 5'd8);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'hCAFEBABE || bus.resp_tag !== 5'd7)
        $display("FAIL bp_hold%0d got %0b/%h/%0d want 1/cafebabe/7", i, bus.resp_valid, bus.resp_data, bus.resp_tag); else passed++;
      checks++; if (bus.req_ready !== 1'b0) $display("FAIL bp_ready%0d got %0b want 0", i, bus.req_ready); else passed++;
    end
    bus.req_valid = 1'b0;
    checks++; if (wr_cycles != w0) $display("FAIL bp_ignored_req got %0d want %0d", wr_cycles, w0); else passed++;
    bus.resp_ready = 1'b1;
    @(posedge clock); #1;
    bus.resp_ready = 1'b0;
    checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0)
      $display("FAIL bp_release got %0b/%0b want 1/0", bus.req_ready, bus.resp_valid); else passed++;
  endtask

  task automatic test_reset_midop();
    logic ok; logic seen; int w0;
    int lat; logic [31:0] rd; logic [4:0] rt; logic re;
    set_req(1'b0, 3'd2, 32'h50, 32'd0, 5'd9);
    wait_accept(ok);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++; if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || mem_write !== 1'b0)
      $display("FAIL rlw_ctrl got %0b/%0b/%0b want 0/0/0", bus.req_ready, bus.resp_valid, mem_write); else passed++;
    checks++; if (mem_width !== 4'd4 || mem_address !== 32'd0 || mem_data_out !== 32'd0 || bus.resp_data !== 32'd0)
      $display("FAIL rlw_mem got %0d/%h/%h/%h want 4/0/0/0", mem_width, mem_address, mem_data_out, bus.resp_data); else passed++;
    seen = 1'b0;
    repeat (5) begin @(posedge clock); #1; seen |= bus.resp_valid; end
    checks++; if (seen !== 1'b0) $display("FAIL rlw_no_resp got %0b want 0", seen); else passed++;

    put_word(8'h58, 32'h11223344);
    w0 = wr_cycles;
    set_req(1'b1, 3'd2, 32'h58, 32'hDEADBEEF, 5'd11);
    wait_accept(ok);
    reset = 1'b1;
    #1;
    checks++; if (mem_write !== 1'b0) $display("FAIL rsw_mem_write got %0b want 0", mem_write); else passed++;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++; if (wr_cycles != w0 || word_at(8'h58) !== 32'h11223344)
      $display("FAIL rsw_not_written got %0d/%h want %0d/11223344", wr_cycles, word_at(8'h58), w0); else passed++;
    seen = 1'b0;
    repeat (4) begin @(posedge clock); #1; seen |= bus.resp_valid; end
    checks++; if (seen !== 1'b0) $display("FAIL rsw_no_resp got %0b want 0", seen); else passed++;
    run_req(1'b0, 3'd2, 32'h58, 32'd0, 5'd12, lat, rd, rt, re);
    checks++; if (rd !== 32'h11223344 || lat != 3 || rt !== 5'd12)
      $display("FAIL rsw_next_lw got %h/%0d/%0d want 11223344/3/12", rd, lat, rt); else passed++;
  endtask

  task automatic test_back_to_back();
    logic        st  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3  [5] = '{3'd2, 3'd2, 3'd4, 3'd1, 3'd1};
    logic [31:0] adr [5] = '{32'h60, 32'h60, 32'h61, 32'h63, 32'h62};
    logic [31:0] exd [5] = '{32'd0, 32'hA5A51234, 32'h00000012, 32'd0, 32'hFFFFA5A5};
    logic        exe [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] gd  [5];
    logic [4:0]  gt  [5];
    logic        ge  [5];
    int idx; int nresp; int w0; logic acc; logic rv; logic [31:0] d; logic [4:0] t; logic e;
    w0 = wr_cycles; idx = 0; nresp = 0;
    bus.resp_ready = 1'b1;
    set_req(st[0], f3[0], adr[0], 32'hA5A51234, 5'd1);
    for (int cyc = 0; cyc < 100 && nresp < 5; cyc++) begin
      acc = bus.req_valid & bus.req_ready;
      rv = bus.resp_valid; d = bus.resp_data; t = bus.resp_tag; e = bus.resp_error;
      @(posedge clock); #1;
      if (rv) begin gd[nresp] = d; gt[nresp] = t; ge[nresp] = e; nresp++; end
      if (acc) begin
        idx++;
        if (idx < 5) set_req(st[idx], f3[idx], adr[idx], 32'hA5A51234, 5'(idx + 1));
        else bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b0;
    checks++; if (nresp != 5 || idx != 5) $display("FAIL b2b_count got %0d/%0d want 5/5", nresp, idx); else passed++;
    for (int i = 0; i < nresp; i++) begin
      checks++; if (gt[i] !== 5'(i + 1)) $display("FAIL b2b%0d_tag got %0d want %0d", i, gt[i], i + 1); else passed++;
      checks++; if (gd[i] !== exd[i] || ge[i] !== exe[i])
        $display("FAIL b2b%0d_data got %h/%0b want %h/%0b", i, gd[i], ge[i], exd[i], exe[i]); else passed++;
    end
    checks++; if (wr_cycles - w0 != 1) $display("FAIL b2b_writes got %0d want 1", wr_cycles - w0); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = '0;
    bus.req_address = '0; bus.req_data = '0; bus.req_tag = '0; bus.resp_ready = 1'b0;
    test_reset();
    test_loads();
    test_store_byte();
    test_errors();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
